// File: rtl/keypad_pkg.sv
`default_nettype none
// ============================================================================
// Module   : keypad_pkg
// Purpose  : Shared key codes, scanner FSM state encoding and the 4x4
//            row/column to key-code lookup for the matrix keypad scanner.
// Revision : 1.0  initial release
// ============================================================================
package keypad_pkg;

   localparam logic [3:0] KEY_0    = 4'd0;
   localparam logic [3:0] KEY_1    = 4'd1;
   localparam logic [3:0] KEY_2    = 4'd2;
   localparam logic [3:0] KEY_3    = 4'd3;
   localparam logic [3:0] KEY_4    = 4'd4;
   localparam logic [3:0] KEY_5    = 4'd5;
   localparam logic [3:0] KEY_6    = 4'd6;
   localparam logic [3:0] KEY_7    = 4'd7;
   localparam logic [3:0] KEY_8    = 4'd8;
   localparam logic [3:0] KEY_9    = 4'd9;
   localparam logic [3:0] KEY_A    = 4'd10;
   localparam logic [3:0] KEY_B    = 4'd11;
   localparam logic [3:0] KEY_C    = 4'd12;
   localparam logic [3:0] KEY_D    = 4'd13;
   localparam logic [3:0] KEY_STAR = 4'd14;
   localparam logic [3:0] KEY_HASH = 4'd15;

   typedef enum logic [1:0] {
      SCAN     = 2'd0,
      DEBOUNCE = 2'd1,
      PRESSED  = 2'd2,
      RELEASE  = 2'd3
   } kp_state_t;

   // Physical keypad legend: row-major, row 0 at the top.
   function automatic logic [3:0] code_of(input logic [1:0] row, input logic [1:0] col);
      logic [3:0] code;
      case ({row, col})
         4'h0:    code = KEY_1;
         4'h1:    code = KEY_2;
         4'h2:    code = KEY_3;
         4'h3:    code = KEY_A;
         4'h4:    code = KEY_4;
         4'h5:    code = KEY_5;
         4'h6:    code = KEY_6;
         4'h7:    code = KEY_B;
         4'h8:    code = KEY_7;
         4'h9:    code = KEY_8;
         4'hA:    code = KEY_9;
         4'hB:    code = KEY_C;
         4'hC:    code = KEY_STAR;
         4'hD:    code = KEY_0;
         4'hE:    code = KEY_HASH;
         4'hF:    code = KEY_D;
         default: code = KEY_0;
      endcase
      return code;
   endfunction

endpackage
`default_nettype wire

// File: rtl/keypad_sync2.sv
`default_nettype none
// ============================================================================
// Module   : keypad_sync2
// Purpose  : 4-bit two-flop synchroniser for the asynchronous keypad rows.
//            Resets to all-ones, i.e. "no key pressed".
// Revision : 1.0  initial release
// ============================================================================
module keypad_sync2 (
   input  logic       clk,
   input  logic       rstn,
   input  logic [3:0] d,
   output logic [3:0] q
);

   logic [3:0] r_meta;
   logic [3:0] r_sync;

   // Two-stage capture of the raw rows into the clk domain
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_meta <= 4'hF;
         r_sync <= 4'hF;
      end else begin
         r_meta <= d;
         r_sync <= r_meta;
      end
   end

   assign q = r_sync;

endmodule
`default_nettype wire

// File: rtl/keypad_scanner.sv
`default_nettype none
// ============================================================================
// Module   : keypad_scanner
// Purpose  : Column-scans a 4x4 active-low keypad, debounces presses and
//            releases on sample ticks and emits one key code strobe per press.
//            Optional macro KEYPAD_REPEAT_EN adds auto-repeat strobes while a
//            key stays held.
// Revision : 1.0  initial release
// ============================================================================
module keypad_scanner #(
   parameter int SCAN_DIV     = 1000,
   parameter int DEBOUNCE_CNT = 8,
   parameter int REPEAT_TICKS = 200
) (
   input  logic       clk,
   input  logic       rstn,
   input  logic [3:0] row_in,
   output logic [3:0] col_out,
   output logic [3:0] key_value,
   output logic       value_en,
   output logic       key_held
);
   import keypad_pkg::*;

   localparam int DIV_W = $clog2(SCAN_DIV);
   localparam int DBC_W = $clog2(DEBOUNCE_CNT + 1);
   localparam logic [DBC_W-1:0] c_dbc_max = DBC_W'(DEBOUNCE_CNT);
   localparam logic [DBC_W-1:0] c_dbc_one = DBC_W'(1);

   // Out-of-range parameters are flagged by this marker block in the netlist
   if (SCAN_DIV < 4 || DEBOUNCE_CNT < 1 || REPEAT_TICKS < 1) begin : g_param_range_error
   end

   logic [3:0]       w_row_sync;
   logic [DIV_W-1:0] r_div;
   logic             w_tick;
   logic             w_any_low;
   logic [1:0]       w_row_idx;
   logic [3:0]       w_code;

   kp_state_t        r_state,     w_state_nxt;
   logic [1:0]       r_col,       w_col_nxt;
   logic [3:0]       r_cand,      w_cand_nxt;
   logic [DBC_W-1:0] r_dbc,       w_dbc_nxt;
   logic [DBC_W-1:0] r_rel,       w_rel_nxt;
   logic [3:0]       r_key_value, w_key_value_nxt;
   logic             r_value_en,  w_value_en_nxt;
   logic [DBC_W-1:0] w_dbc_inc;
   logic [DBC_W-1:0] w_rel_inc;

   keypad_sync2 u_sync (
      .clk  (clk),
      .rstn (rstn),
      .d    (row_in),
      .q    (w_row_sync)
   );

   // Column dwell divider; the tick is the wrap from SCAN_DIV-1 back to 0
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_div <= '0;
      end else begin
         r_div <= w_tick ? '0 : r_div + DIV_W'(1);
      end
   end

   assign w_tick    = (r_div == DIV_W'(SCAN_DIV - 1));
   assign w_any_low = ~&w_row_sync;

   // Encoder: the lowest-numbered low row wins when several are low
   always_comb begin
      w_row_idx = 2'd0;
      for (int i = 3; i >= 0; i--) begin
         if (!w_row_sync[i]) begin
            w_row_idx = 2'(i);
         end
      end
   end

   assign w_code    = code_of(w_row_idx, r_col);
   assign w_dbc_inc = (r_dbc == c_dbc_max) ? r_dbc : r_dbc + DBC_W'(1);
   assign w_rel_inc = (r_rel == c_dbc_max) ? r_rel : r_rel + DBC_W'(1);

`ifdef KEYPAD_REPEAT_EN
   localparam int RPT_W = $clog2(REPEAT_TICKS + 1);
   localparam logic [RPT_W-1:0] c_rpt_max = RPT_W'(REPEAT_TICKS);

   logic [RPT_W-1:0] r_rpt, w_rpt_nxt, w_rpt_inc;

   assign w_rpt_inc = (r_rpt == c_rpt_max) ? r_rpt : r_rpt + RPT_W'(1);

   // Auto-repeat tick counter, only meaningful while in PRESSED
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_rpt <= '0;
      end else begin
         r_rpt <= w_rpt_nxt;
      end
   end
`endif

   // FSM and datapath state register
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state     <= SCAN;
         r_col       <= 2'd0;
         r_cand      <= KEY_0;
         r_dbc       <= '0;
         r_rel       <= '0;
         r_key_value <= KEY_0;
         r_value_en  <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_col       <= w_col_nxt;
         r_cand      <= w_cand_nxt;
         r_dbc       <= w_dbc_nxt;
         r_rel       <= w_rel_nxt;
         r_key_value <= w_key_value_nxt;
         r_value_en  <= w_value_en_nxt;
      end
   end

   // Next-state logic: the column only moves on a tick, acceptance of a
   // debounced press happens the clk after the count completes
   always_comb begin
      w_state_nxt     = r_state;
      w_col_nxt       = r_col;
      w_cand_nxt      = r_cand;
      w_dbc_nxt       = r_dbc;
      w_rel_nxt       = r_rel;
      w_key_value_nxt = r_key_value;
      w_value_en_nxt  = 1'b0;
`ifdef KEYPAD_REPEAT_EN
      // Anything outside PRESSED keeps rpt clear, so every entry starts at 0
      w_rpt_nxt       = (r_state == PRESSED) ? r_rpt : '0;
`endif
      case (r_state)
         SCAN: begin
            if (w_tick) begin
               if (w_any_low) begin
                  w_cand_nxt  = w_code;
                  w_dbc_nxt   = c_dbc_one;
                  w_state_nxt = DEBOUNCE;
               end else begin
                  w_col_nxt   = r_col + 2'd1;
               end
            end
         end
         DEBOUNCE: begin
            if (r_dbc == c_dbc_max) begin
               w_key_value_nxt = r_cand;
               w_value_en_nxt  = 1'b1;
               w_dbc_nxt       = '0;
               w_rel_nxt       = '0;
               w_state_nxt     = PRESSED;
            end else if (w_tick) begin
               if (w_any_low && (w_code == r_cand)) begin
                  w_dbc_nxt   = w_dbc_inc;
               end else begin
                  w_dbc_nxt   = '0;
                  w_col_nxt   = r_col + 2'd1;
                  w_state_nxt = SCAN;
               end
            end
         end
         PRESSED: begin
            if (w_tick) begin
               if (!w_any_low) begin
                  // A one-tick release count finishes immediately
                  if (c_dbc_one == c_dbc_max) begin
                     w_rel_nxt   = '0;
                     w_col_nxt   = r_col + 2'd1;
                     w_state_nxt = SCAN;
                  end else begin
                     w_rel_nxt   = c_dbc_one;
                     w_state_nxt = RELEASE;
                  end
               end else begin
`ifdef KEYPAD_REPEAT_EN
                  if (w_rpt_inc == c_rpt_max) begin
                     w_value_en_nxt = 1'b1;
                     w_rpt_nxt      = '0;
                  end else begin
                     w_rpt_nxt      = w_rpt_inc;
                  end
`endif
               end
            end
         end
         RELEASE: begin
            if (w_tick) begin
               if (w_any_low) begin
                  w_rel_nxt   = '0;
                  w_state_nxt = PRESSED;
               end else if (w_rel_inc == c_dbc_max) begin
                  w_rel_nxt   = '0;
                  w_col_nxt   = r_col + 2'd1;
                  w_state_nxt = SCAN;
               end else begin
                  w_rel_nxt   = w_rel_inc;
               end
            end
         end
         default: begin
            w_state_nxt = SCAN;
         end
      endcase
   end

   assign col_out   = ~(4'b0001 << r_col);
   assign key_value = r_key_value;
   assign value_en  = r_value_en;
   assign key_held  = (r_state == PRESSED) || (r_state == RELEASE);

endmodule
`default_nettype wire

// File: tb/tb_keypad_scanner.sv
`default_nettype none
// ============================================================================
// Module   : tb_keypad_scanner
// Purpose  : Directed bench for keypad_scanner with a behavioural 4x4 keypad
//            (a pressed key pulls its row low while its column is driven low).
// Revision : 1.0  initial release
// ============================================================================
module tb_keypad_scanner;

   localparam int SCAN_DIV     = 4;
   localparam int DEBOUNCE_CNT = 3;
   localparam int REPEAT_TICKS = 5;
`ifdef KEYPAD_REPEAT_EN
   localparam int EXP_HOLD_STROBES = 4;
`else
   localparam int EXP_HOLD_STROBES = 1;
`endif

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic [3:0]  row_in;
   logic [3:0]  col_out;
   logic [3:0]  key_value;
   logic        value_en;
   logic        key_held;
   logic [15:0] pressed = 16'h0;   // bit r*4+c

   logic [1:0]  tb_div;
   int          strobe_cnt = 0;
   logic [3:0]  last_strobe_val = 4'd0;
   int          n_tests = 0;
   int          n_fail  = 0;

   typedef struct {
      string      name;
      int         row;
      int         col;
      logic [3:0] code;
   } vec_t;
   vec_t vecs [9];

   always #5 clk = ~clk;

   keypad_scanner #(
      .SCAN_DIV     (SCAN_DIV),
      .DEBOUNCE_CNT (DEBOUNCE_CNT),
      .REPEAT_TICKS (REPEAT_TICKS)
   ) dut (
      .clk       (clk),
      .rstn      (rstn),
      .row_in    (row_in),
      .col_out   (col_out),
      .key_value (key_value),
      .value_en  (value_en),
      .key_held  (key_held)
   );

   // Keypad model
   always_comb begin
      row_in = 4'hF;
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 4; c++) begin
            if (pressed[r*4+c] && !col_out[c]) row_in[r] = 1'b0;
         end
      end
   end

   // Reference dwell counter: a tick happens on the edge after tb_div==3
   always @(posedge clk or negedge rstn) begin
      if (!rstn) tb_div <= 2'd0;
      else       tb_div <= (tb_div == 2'(SCAN_DIV - 1)) ? 2'd0 : tb_div + 2'd1;
   end

   // Strobe monitor
   always @(posedge clk) begin
      #1;
      if (value_en === 1'b1) begin
         strobe_cnt      = strobe_cnt + 1;
         last_strobe_val = key_value;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic wait_tick();
      @(negedge clk);
      while (tb_div != 2'(SCAN_DIV - 1)) @(negedge clk);
      @(posedge clk);
      #1;
   endtask

   task automatic wait_ticks(input int n);
      for (int i = 0; i < n; i++) wait_tick();
   endtask

   task automatic wait_strobe(input int base, input string name);
      int i;
      i = 0;
      while (strobe_cnt == base && i < 200) begin
         @(negedge clk);
         i++;
      end
      check({name, " strobe seen"}, strobe_cnt - base, 1);
   endtask

   task automatic wait_idle(input string name);
      int i;
      i = 0;
      while (key_held !== 1'b0 && i < 100) begin
         @(negedge clk);
         i++;
      end
      check({name, " key_held released"}, key_held, 0);
   endtask

   task automatic press_one(input string name, input int r, input int c, input logic [3:0] code);
      int base;
      base = strobe_cnt;
      pressed = 16'h0;
      pressed[r*4+c] = 1'b1;
      wait_strobe(base, name);
      check({name, " key_value"}, key_value, code);
      check({name, " key_held"}, key_held, 1);
      pressed = 16'h0;
      wait_idle(name);
      check({name, " one strobe"}, strobe_cnt - base, 1);
   endtask

   initial begin : watchdog
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      int base;
      logic [3:0] exp_cols [4];
      vecs[0] = '{"key7", 2, 0, 4'd7};
      vecs[1] = '{"key1", 0, 0, 4'd1};
      vecs[2] = '{"keyA", 0, 3, 4'd10};
      vecs[3] = '{"keyStar", 3, 0, 4'd14};
      vecs[4] = '{"key0", 3, 1, 4'd0};
      vecs[5] = '{"keyHash", 3, 2, 4'd15};
      vecs[6] = '{"keyD", 3, 3, 4'd13};
      vecs[7] = '{"key9", 2, 2, 4'd9};
      vecs[8] = '{"key5", 1, 1, 4'd5};
      exp_cols[0] = 4'b1101;
      exp_cols[1] = 4'b1011;
      exp_cols[2] = 4'b0111;
      exp_cols[3] = 4'b1110;

      // Reset values and idle column rotation
      repeat (3) @(posedge clk);
      #1;
      check("reset col_out", col_out, 4'b1110);
      check("reset key_value", key_value, 0);
      check("reset value_en", value_en, 0);
      check("reset key_held", key_held, 0);
      @(negedge clk) rstn = 1'b1;
      for (int i = 0; i < 4; i++) begin
         wait_tick();
         check("idle rotate col_out", col_out, exp_cols[i]);
      end

      // Table of single clean presses
      for (int i = 0; i < 9; i++) begin
         press_one(vecs[i].name, vecs[i].row, vecs[i].col, vecs[i].code);
      end

      // Two rows low in one column: lowest row ('1') wins over '7'
      base = strobe_cnt;
      pressed = 16'h0;
      pressed[0] = 1'b1;
      pressed[8] = 1'b1;
      wait_strobe(base, "rowprio");
      check("rowprio key_value", key_value, 1);
      pressed = 16'h0;
      wait_idle("rowprio");

      // 'A' bouncing: low for one tick, high for one tick, then steady
      for (int i = 0; i < 8 && col_out != 4'b0111; i++) wait_tick();
      base = strobe_cnt;
      pressed = 16'h0;
      pressed[3] = 1'b1;
      wait_tick();
      check("bounce column frozen", col_out, 4'b0111);
      pressed = 16'h0;
      wait_tick();
      check("bounce rescan column", col_out, 4'b1110);
      check("bounce no strobe", strobe_cnt - base, 0);
      pressed[3] = 1'b1;
      wait_strobe(base, "bounce");
      check("bounce key_value", key_value, 10);
      pressed = 16'h0;
      wait_idle("bounce");
      check("bounce one strobe", strobe_cnt - base, 1);

      // 'A' then '0' as two separate presses
      base = strobe_cnt;
      press_one("seqA", 0, 3, 4'd10);
      press_one("seq0", 3, 1, 4'd0);
      check("seq two strobes", strobe_cnt - base, 2);

      // '5' held, '#' added: ignored until '5' is released
      base = strobe_cnt;
      pressed = 16'h0;
      pressed[5] = 1'b1;
      wait_strobe(base, "hold5");
      check("hold5 key_value", key_value, 5);
      pressed[14] = 1'b1;
      wait_ticks(8);
      check("hash ignored strobes", strobe_cnt - base, 1);
      check("hash ignored key_value", key_value, 5);
      check("hash ignored key_held", key_held, 1);
      pressed[5] = 1'b0;
      wait_strobe(base + 1, "hash after release");
      check("hash key_value", key_value, 15);
      pressed = 16'h0;
      wait_idle("hash");

      // Reset during DEBOUNCE on '7', then re-detection with exact latency
      pressed = 16'h0;
      pressed[8] = 1'b1;
      wait_tick();
      for (int i = 0; i < 8 && col_out != 4'b1110; i++) wait_tick();
      wait_tick();
      base = strobe_cnt;
      @(negedge clk);
      #2 rstn = 1'b0;
      #1;
      check("midreset key_value", key_value, 0);
      check("midreset value_en", value_en, 0);
      check("midreset key_held", key_held, 0);
      check("midreset col_out", col_out, 4'b1110);
      repeat (3) @(negedge clk);
      check("midreset no strobe", strobe_cnt - base, 0);
      @(negedge clk) rstn = 1'b1;
      for (int e = 1; e <= 13; e++) begin
         @(posedge clk);
         #1;
         if (e == 12) check("latency early value_en", value_en, 0);
      end
      check("latency value_en", value_en, 1);
      check("latency key_value", key_value, 7);
      pressed = 16'h0;
      wait_idle("redetect");
      check("redetect one strobe", strobe_cnt - base, 1);

      // Hold '3' for 17 ticks after acceptance
      base = strobe_cnt;
      pressed = 16'h0;
      pressed[2] = 1'b1;
      wait_strobe(base, "hold3");
      check("hold3 key_value", key_value, 3);
      wait_ticks(17);
      pressed = 16'h0;
      wait_idle("hold3");
      check("hold3 strobe count", strobe_cnt - base, EXP_HOLD_STROBES);
      check("hold3 last value", last_strobe_val, 3);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
